// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 size codes,
// FSM state encoding and the width of the bus-wait timeout counter.
package lsu_pkg;

  // funct3 access size/sign codes for RV32I loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Timeout counter width; holds 0..254 for the largest TIMEOUT of 255
  localparam int TIMEOUT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Purpose: byte-lane steering for stores, load extract/extend, access legality check.
// Latency: purely combinational.
// Backpressure: none; the parent FSM decides when outputs are used.
// Ports: is_load/is_store/funct3/addr_lo/wdata describe the incoming request
//        (-> st_be, st_wdata, req_fault); ld_funct3/ld_addr_lo/rword describe the
//        latched load and the returned bus word (-> ld_data).
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        req_fault,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rword,
  output logic [31:0] ld_data
);

  logic legal;
  logic misaligned;
  logic [31:0] shifted;
  logic [15:0] half;

  // Store steering: replicate data across lanes, enable only the addressed ones
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdata;
    case (funct3)
      F3_B: begin
        st_be    = 4'b0001 << addr_lo;
        st_wdata = {4{wdata[7:0]}};
      end
      F3_H: begin
        st_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wdata;
      end
    endcase
  end

  // Legality: loads and stores together is never valid; size/sign codes differ per direction
  always_comb begin
    legal = 1'b0;
    if (is_load && is_store)
      legal = 1'b0;
    else if (is_load)
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    else if (is_store)
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);

    // funct3[1:0] is the size: 01 half, 10 word
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase

    req_fault = (is_load || is_store) && (!legal || misaligned);
  end

  // Load extract: bring the addressed byte down to bit 0, then extend
  always_comb begin
    shifted = rword >> {ld_addr_lo, 3'b000};
    half    = ld_addr_lo[1] ? rword[31:16] : rword[15:0];
    case (ld_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {24'd0, shifted[7:0]};
      F3_H:    ld_data = {{16{half[15]}}, half};
      F3_HU:   ld_data = {16'd0, half};
      default: ld_data = rword;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: RV32I memory stage; runs LB/LH/LW/LBU/LHU/SB/SH/SW over a req/ack word bus.
// Latency: 3 cycles minimum (IDLE, BUS with ack, DONE), +1 per bus wait cycle.
// Backpressure: stalls the core from request until DONE; bus_req held until ack or timeout.
// Ports: clk/reset; core side mem_read, mem_write, funct3, addr, wdata -> stall, done,
//        rdata, fault; bus side bus_req, bus_we, bus_addr, bus_be, bus_wdata <- bus_ack, bus_rdata.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_t state_q, state_d;
  logic                 op;
  logic                 req_fault;
  logic [3:0]           st_be;
  logic [31:0]          st_wdata;
  logic [31:0]          ld_data;
  logic [2:0]           f3_q;
  logic [1:0]           lo_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 timeout_hit;

  assign op          = mem_read | mem_write;
  assign timeout_hit = (cnt_q == TIMEOUT_W'(TIMEOUT - 1));

  lsu_align u_align (
    .is_load    (mem_read),
    .is_store   (mem_write),
    .funct3     (funct3),
    .addr_lo    (addr[1:0]),
    .wdata      (wdata),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .req_fault  (req_fault),
    .ld_funct3  (f3_q),
    .ld_addr_lo (lo_q),
    .rword      (bus_rdata),
    .ld_data    (ld_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (op) state_d = req_fault ? DONE : BUS;
      BUS:     if (bus_ack || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; stall covers the request cycle so the core freezes immediately
  always_comb begin
    stall   = !reset && (((state_q == IDLE) && op) || (state_q == BUS));
    bus_req = (state_q == BUS);
    done    = (state_q == DONE);
  end

  // Request latches, timeout counter and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_we    <= 1'b0;
      bus_be    <= 4'b0000;
      bus_addr  <= '0;
      bus_wdata <= '0;
      f3_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      rdata     <= '0;
      fault     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op) begin
            if (req_fault) begin
              fault <= 1'b1;
              rdata <= '0;
            end else begin
              bus_we    <= mem_write;
              bus_be    <= mem_write ? st_be : 4'b1111;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wdata <= mem_write ? st_wdata : '0;
              f3_q      <= funct3;
              lo_q      <= addr[1:0];
              cnt_q     <= '0;
            end
          end
        end
        BUS: begin
          // Ack beats a simultaneous timeout
          if (bus_ack) begin
            fault  <= 1'b0;
            rdata  <= bus_we ? '0 : ld_data;
            bus_we <= 1'b0;
            bus_be <= 4'b0000;
          end else if (timeout_hit) begin
            fault  <= 1'b1;
            rdata  <= '0;
            bus_we <= 1'b0;
            bus_be <= 4'b0000;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
